spi_xfer_ctrl: RTL and testbench

//   SPI master transaction sequencer. Owns one full-duplex transfer end to end:

---
 rtl/spi_xfer_ctrl.sv | 165 ++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// SPI master sequencer: one full-duplex DATA_W-bit transfer per accepted start, all four CPOL/CPHA modes.
// Latency: done arrives 1+CLK_DIV*(2*DATA_W+1) cycles after start; start is ignored while busy.
module spi_xfer_ctrl #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W) + 1;
    localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    // Only the bits still to be sent after the MSB, which goes out at accept time.
    logic [DATA_W-2:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                cs_n_q, cs_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;

    logic div_tick;
    logic is_capture;
    logic skip_shift;

    assign div_tick   = (div_q == DIV_MAX);
    assign is_capture = cpha_q ? edge_q[0] : ~edge_q[0];
    assign skip_shift = cpha_q && (edge_q == '0);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        edge_d    = edge_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rx_data_d = rx_data_q;

        case (state_q)
            IDLE: begin
                sclk_d = cpol;
                if (start) begin
                    state_d = SETUP;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    tx_d    = tx_data[DATA_W-2:0];
                    mosi_d  = tx_data[DATA_W-1];
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    edge_d  = '0;
                end
            end
            SETUP, XFER: begin
                if (div_tick) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + EDGE_W'(1);
                    if (is_capture) begin
                        rx_d = {rx_q[DATA_W-2:0], miso};
                    end else if (!skip_shift) begin
                        mosi_d = tx_q[DATA_W-2];
                        tx_d   = tx_q << 1;
                    end
                    if (edge_q == EDGE_LAST) begin
                        state_d = HOLD;
                    end else begin
                        state_d = XFER;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HOLD: begin
                sclk_d = cpol_q;
                if (div_tick) begin
                    state_d   = IDLE;
                    div_d     = '0;
                    cs_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_q;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            edge_q    <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: SPI slave model, per-edge monitor and done scoreboard on the default
// instance, plus a CLK_DIV=1 loopback instance for the fast-divider timing.
module tb_spi_xfer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso = 1'b0;
    logic       sclk, mosi, cs_n, busy, done;
    logic [7:0] rx_data;

    logic       start1 = 1'b0;
    logic       sclk1, mosi1, cs_n1, busy1, done1;
    logic [7:0] rx_data1;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    spi_xfer_ctrl #(.DATA_W(8), .CLK_DIV(2)) u_dut (
        .clk(clk), .reset(reset), .start(start), .cpol(cpol), .cpha(cpha),
        .tx_data(tx_data), .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .busy(busy), .done(done), .rx_data(rx_data)
    );

    spi_xfer_ctrl #(.DATA_W(8), .CLK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .cpol(cpol), .cpha(cpha),
        .tx_data(tx_data), .miso(mosi1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1),
        .busy(busy1), .done(done1), .rx_data(rx_data1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic [7:0] tx;
        logic [7:0] rx;
    } exp_t;

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic [7:0] tx;
        logic [7:0] slave;
        logic [7:0] exp_rx;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor + slave: miso presents the next slave bit after every capture edge seen.
    logic busy_p = 1'b0;
    logic sclk_p = 1'b0;
    int   t0 = 0;
    int   edge_n = 0;
    int   rises = 0;
    int   falls = 0;
    int   cs_low = 0;

    always @(negedge clk) begin
        int caps;
        int c;
        if (reset) begin
            miso = 1'b0;
            edge_n = 0;
        end else begin
            if (busy && !busy_p) begin
                if (sb.size() > 0) cur = sb[0];
                t0 = cyc - 1;
                edge_n = 0;
                rises = 0;
                falls = 0;
                cs_low = 0;
            end
            if (!cs_n) cs_low++;
            if (!cs_n && (sclk !== sclk_p)) begin
                if (sclk) rises++;
                else falls++;
                if (cur.cpha ? (edge_n % 2 == 1) : (edge_n % 2 == 0)) begin
                    c = cur.cpha ? (edge_n - 1) / 2 : edge_n / 2;
                    chk("mosi_at_capture", {31'd0, mosi}, {31'd0, cur.tx[7-c]});
                end
                edge_n++;
            end
            if (done) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: got done=1 want no done (cycle %0d)", cyc);
                end else begin
                    cur = sb.pop_front();
                    chk("rx_data", {24'd0, rx_data}, {24'd0, cur.rx});
                    chk("done_cycle", cyc - t0, 35);
                    chk("done_busy_low", {31'd0, busy}, 0);
                    chk("done_cs_n_high", {31'd0, cs_n}, 1);
                    chk("end_sclk_cpol", {31'd0, sclk}, {31'd0, cur.cpol});
                    chk("rising_edges", rises, 8);
                    chk("falling_edges", falls, 8);
                    chk("cs_low_cycles", cs_low, 34);
                end
            end
            caps = cur.cpha ? edge_n / 2 : (edge_n + 1) / 2;
            miso = (caps < 8) ? cur.rx[7-caps] : 1'b0;
        end
        busy_p = busy;
        sclk_p = sclk;
    end

    task automatic do_start(input exp_t e);
        @(negedge clk);
        cpol = e.cpol;
        cpha = e.cpha;
        tx_data = e.tx;
        repeat (2) @(negedge clk);
        start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input bit disturb);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) break;
            if (disturb) begin
                cpol = $urandom_range(0, 1);
                cpha = $urandom_range(0, 1);
                tx_data = 8'($urandom);
            end
        end
        if (k == 200) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done within 200 cycles want done");
        end
    endtask

    initial begin
        exp_t e;
        int   k;
        int   toggles;
        int   first_tog;
        int   ndone;
        logic s1p;

        vecs[0] = '{cpol: 1'b0, cpha: 1'b0, tx: 8'hA5, slave: 8'h3C, exp_rx: 8'h3C};
        vecs[1] = '{cpol: 1'b0, cpha: 1'b1, tx: 8'hA5, slave: 8'h3C, exp_rx: 8'h3C};
        vecs[2] = '{cpol: 1'b1, cpha: 1'b0, tx: 8'hA5, slave: 8'h3C, exp_rx: 8'h3C};
        vecs[3] = '{cpol: 1'b1, cpha: 1'b1, tx: 8'hA5, slave: 8'h3C, exp_rx: 8'h3C};
        vecs[4] = '{cpol: 1'b0, cpha: 1'b0, tx: 8'hFF, slave: 8'h00, exp_rx: 8'h00};
        vecs[5] = '{cpol: 1'b1, cpha: 1'b1, tx: 8'h00, slave: 8'hFF, exp_rx: 8'hFF};
        vecs[6] = '{cpol: 1'b0, cpha: 1'b1, tx: 8'h81, slave: 8'h7E, exp_rx: 8'h7E};

        repeat (3) @(negedge clk);
        chk("rst_sclk", {31'd0, sclk}, 0);
        chk("rst_mosi", {31'd0, mosi}, 0);
        chk("rst_cs_n", {31'd0, cs_n}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_rx_data", {24'd0, rx_data}, 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            e = '{cpol: vecs[i].cpol, cpha: vecs[i].cpha, tx: vecs[i].tx, rx: vecs[i].exp_rx};
            do_start(e);
            wait_done(1'b0);
            @(negedge clk);
            chk("idle_sclk_cpol", {31'd0, sclk}, {31'd0, vecs[i].cpol});
        end

        // Start pulsed at cycle 5 is ignored; start in the done cycle begins a second transfer.
        e = '{cpol: 1'b0, cpha: 1'b0, tx: 8'hA5, rx: 8'h3C};
        do_start(e);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0);
        tx_data = 8'h5A;
        sb.push_back('{cpol: 1'b0, cpha: 1'b0, tx: 8'h5A, rx: 8'hC6});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_cs_n_low", {31'd0, cs_n}, 0);
        chk("b2b_busy", {31'd0, busy}, 1);
        wait_done(1'b0);

        // Reset at cycle 10 aborts the transfer.
        e = '{cpol: 1'b1, cpha: 1'b0, tx: 8'hA5, rx: 8'h3C};
        do_start(e);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_cs_n", {31'd0, cs_n}, 1);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_sclk", {31'd0, sclk}, 0);
        chk("abort_rx_data", {24'd0, rx_data}, 0);
        chk("abort_done", {31'd0, done}, 0);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        e = '{cpol: 1'b0, cpha: 1'b1, tx: 8'h3C, rx: 8'hA5};
        do_start(e);
        wait_done(1'b0);

        // Inputs churned mid-transfer must not disturb the latched transfer.
        e = '{cpol: 1'b0, cpha: 1'b0, tx: 8'hA5, rx: 8'h3C};
        do_start(e);
        wait_done(1'b1);
        cpol = 1'b0;
        cpha = 1'b0;
        tx_data = 8'hC3;
        repeat (3) @(negedge clk);

        // CLK_DIV=1 instance, miso looped back to mosi.
        s1p = sclk1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        toggles = 0;
        first_tog = 0;
        for (k = 1; k < 100; k++) begin
            if (sclk1 !== s1p) begin
                toggles++;
                if (first_tog == 0) first_tog = k;
            end
            s1p = sclk1;
            if (done1) break;
            @(negedge clk);
        end
        chk("div1_done_cycle", k, 18);
        chk("div1_rx_loopback", {24'd0, rx_data1}, 32'h0000_00C3);
        chk("div1_toggles", toggles, 16);
        chk("div1_first_edge", first_tog, 2);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
